absorb_load_stage: RTL and testbench
====================================

# absorb_load_stage

First pipeline stage of the SHAKE core. It accepts the message as a stream of w-bit words and packs it into rate-sized blocks, applying SHAKE padding (domain byte 0x1F, final bit 0x80). Each finished block is handed to the permute/dump stage through the `input_buffer_ready` / `last_block_in_buffer` set/clear handshake. Output size and mode are held stable for the permute/dump stage for the whole message.

## Interface
- Parameters: none. `w` (64), `RATE_SHAKE128` (1344) and `RATE_SHAKE256` (1088) come from `keccak_pkg`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a message. Sampled only in IDLE.
- `input_size`  in  32  message length in bytes. Sampled with `start`.
- `output_size_in`  in  32  requested output length. Sampled with `start`.
- `operation_mode_in`  in  2  2'b00 SHAKE128, 2'b01 SHAKE256, others treated as SHAKE128. Sampled with `start`.
- `data_in`  in  w  message word. Byte i is in bits [8i+7:8i].
- `valid_in`  in  1  `data_in` is valid.
- `ready_out`  out  1  a word is accepted when `valid_in & ready_out`.
- `rate_output`  out  RATE_SHAKE128  packed block; bits above the rate are zero in SHAKE256.
- `output_size`  out  32  registered copy of `output_size_in`.
- `operation_mode`  out  2  registered copy of `operation_mode_in`.
- `input_buffer_ready`  out  1  a block is waiting in `rate_output`.
- `last_block_in_buffer`  out  1  the waiting block is the final padded block.
- `input_buffer_ready_clr`  in  1  permute stage has consumed the block.
- `last_block_in_buffer_clr`  in  1  permute stage has consumed the last flag.

## Operation
- Rate words: RW = 21 for SHAKE128, 17 for SHAKE256.
- Registers: `word_cnt` (5 bits) and `bytes_left` (32 bits). `bytes_left` is loaded from `input_size` and decremented by min(8, `bytes_left`) per accepted word.
- FSM states:
  - IDLE: `ready_out` = 0. On `start`, capture the sizes and mode, zero the buffer, and go to LOAD. If `input_size` = 0, go to PAD instead.
  - LOAD: `ready_out` = !`input_buffer_ready`. An accepted word is written to word slot `word_cnt`. Bytes at index ≥ `bytes_left` within that word are masked to zero.
    - Message ends with room left in the block (`bytes_left` ≤ 8 and, after the word, fewer than 8·RW bytes are used): go to PAD.
    - Block filled (`word_cnt` = RW−1): set `input_buffer_ready` and go to HANDOFF. Record `pad_pending` = (`bytes_left` after the word = 0).
  - PAD: one cycle, `ready_out` = 0.
    - XOR 0x1F into byte P, where P = bytes used in the block.
    - XOR 0x80 into byte 8·RW−1. When P = 8·RW−1 the byte becomes 0x9F.
    - Set `input_buffer_ready` and `last_block_in_buffer`, then go to HANDOFF.
  - HANDOFF: `ready_out` = 0. Wait for `input_buffer_ready` = 0.
    - If the block was last, go to IDLE.
    - Otherwise zero the buffer, reset `word_cnt`, and go to PAD if `pad_pending`, else LOAD.
- Flags are set/clear latches. Set has priority over clear in the same cycle.
- `rate_output`, `output_size` and `operation_mode` are stable while `input_buffer_ready` = 1.

## Timing
- Reset values (all outputs): `ready_out` 0, `input_buffer_ready` 0, `last_block_in_buffer` 0, `rate_output` 0, `output_size` 0, `operation_mode` 0. State is IDLE.
- `start` → `ready_out` = 1 in the next cycle.
- Full block: `input_buffer_ready` rises the cycle after the RW-th word is accepted.
- Padded block: `input_buffer_ready` rises 2 cycles after the last message word is accepted.
- Clear → new block: `input_buffer_ready_clr` in cycle N → `ready_out` = 1 (or PAD) in cycle N+2.
- Throughput in LOAD: one word per cycle, with no bubbles inside a block.
- Boundary cases:
  - `valid_in` while `ready_out` = 0 is ignored, and the word is not consumed.
  - `start` outside IDLE is ignored.
  - Reset mid-message drops the block, clears both flags, and returns to IDLE on the next edge.

## Configuration
- `ABSORB_LOAD_BYTE_SWAP_EN`
  - Defined: `data_in` is byte-reversed before masking and packing (big-endian word input). Byte 7 of the word is the first message byte; masking and the padding position use the swapped order.
  - Undefined: little-endian packing as specified above.

## Test plan
- SHAKE128, `input_size` = 0, `start` → no word accepted. `rate_output` byte 0 = 0x1F, byte 167 = 0x80, all other bytes 0. Both flags = 1.
- SHAKE128, `input_size` = 3, one word 0x…00CCBBAA → bytes 0..3 = AA BB CC 1F, byte 167 = 0x80. Upper 5 bytes of the word are masked.
- SHAKE128, `input_size` = 167 → byte 167 = 0x9F in a single last block.
- SHAKE256, `input_size` = 136 (17 words):
  - Block 1 is pure data with `last_block_in_buffer` = 0.
  - After `input_buffer_ready_clr`, block 2 has byte 0 = 0x1F, byte 135 = 0x80, bits ≥ 1088 = 0, and last = 1.
- Withhold `input_buffer_ready_clr` for 10 cycles with `valid_in` = 1 → `ready_out` = 0 and `rate_output` unchanged. Pulse clr → `ready_out` = 1 two cycles later.
- Assert `rst` = 0 after 5 words of a 400-byte message → flags 0, `ready_out` 0, IDLE. A following `start` with `input_size` = 0 yields the correct pad-only block.

Source files
------------

// File: rtl/absorb_load_stage.sv
// SHAKE absorb front end: packs the w-bit message stream into rate-sized blocks,
// applies SHAKE padding, and hands each block to the permute stage via set/clear flags.
// Optional build macro: ABSORB_LOAD_BYTE_SWAP_EN (big-endian word input).

package keccak_pkg;
  localparam int w             = 64;
  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;
endpackage

module absorb_load_stage
  import keccak_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              input_size,
  input  logic [31:0]              output_size_in,
  input  logic [1:0]               operation_mode_in,
  input  logic [w-1:0]             data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [RATE_SHAKE128-1:0] rate_output,
  output logic [31:0]              output_size,
  output logic [1:0]               operation_mode,
  output logic                     input_buffer_ready,
  output logic                     last_block_in_buffer,
  input  logic                     input_buffer_ready_clr,
  input  logic                     last_block_in_buffer_clr
);

  typedef enum logic [1:0] {IDLE, LOAD, PAD, HANDOFF} state_t;

  localparam int RW128 = RATE_SHAKE128 / w;
  localparam int RW256 = RATE_SHAKE256 / w;
  localparam logic [RATE_SHAKE128-1:0] PAD_DOMAIN = RATE_SHAKE128'(8'h1F);
  localparam logic [RATE_SHAKE128-1:0] PAD_FINAL  = RATE_SHAKE128'(8'h80);

  state_t      state;
  logic [4:0]  word_cnt;
  logic [31:0] bytes_left;
  logic [7:0]  pad_pos;
  logic        pad_pending;
  logic        is_last;

  logic [4:0]               rw_last;
  logic [7:0]               last_byte;
  logic [w-1:0]             word_in;
  logic [w-1:0]             word_masked;
  logic [3:0]               take;
  logic                     accept;
  logic                     last_slot;
  logic                     ends_in_block;
  logic [RATE_SHAKE128-1:0] pad_vec;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rw_last     = (operation_mode == 2'b01) ? 5'(RW256 - 1) : 5'(RW128 - 1);
    last_byte   = (operation_mode == 2'b01) ? 8'(RW256 * 8 - 1) : 8'(RW128 * 8 - 1);
    word_in     = '0;
    word_masked = '0;
`ifdef ABSORB_LOAD_BYTE_SWAP_EN
    for (int i = 0; i < 8; i++) word_in[8*i +: 8] = data_in[8*(7-i) +: 8];
`else
    word_in = data_in;
`endif
    for (int i = 0; i < 8; i++)
      word_masked[8*i +: 8] = (32'(i) < bytes_left) ? word_in[8*i +: 8] : 8'h00;
    take          = (bytes_left < 32'd8) ? bytes_left[3:0] : 4'd8;
    accept        = valid_in & ready_out;
    last_slot     = (word_cnt == rw_last);
    // The message ends here and still leaves at least one free byte for the padding.
    ends_in_block = (bytes_left <= 32'd8) && !(last_slot && take == 4'd8);
    pad_vec       = (PAD_DOMAIN << {pad_pos, 3'b000}) ^ (PAD_FINAL << {last_byte, 3'b000});
  end

  always_ff @(posedge clk) begin
    // NOTE: the wide block buffer is reset too, because its reset value is visible on rate_output.
    if (!rst) begin
      state                <= IDLE;
      ready_out            <= 1'b0;
      rate_output          <= '0;
      output_size          <= '0;
      operation_mode       <= '0;
      input_buffer_ready   <= 1'b0;
      last_block_in_buffer <= 1'b0;
      word_cnt             <= '0;
      bytes_left           <= '0;
      pad_pos              <= '0;
      pad_pending          <= 1'b0;
      is_last              <= 1'b0;
    end else begin
      // NOTE: clears are scheduled first; a later non-blocking set in this block wins.
      if (input_buffer_ready_clr)   input_buffer_ready   <= 1'b0;
      if (last_block_in_buffer_clr) last_block_in_buffer <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            output_size    <= output_size_in;
            operation_mode <= operation_mode_in;
            bytes_left     <= input_size;
            word_cnt       <= '0;
            pad_pos        <= '0;
            rate_output    <= '0;
            if (input_size == 32'd0) begin
              state <= PAD;
            end else begin
              state     <= LOAD;
              ready_out <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            rate_output[{word_cnt, 6'b000000} +: w] <= word_masked;
            bytes_left <= bytes_left - {28'd0, take};
            word_cnt   <= word_cnt + 5'd1;
            if (ends_in_block) begin
              pad_pos   <= {word_cnt, 3'b000} + {4'd0, take};
              state     <= PAD;
              ready_out <= 1'b0;
            end else if (last_slot) begin
              input_buffer_ready <= 1'b1;
              pad_pending        <= (bytes_left <= 32'd8);
              state              <= HANDOFF;
              ready_out          <= 1'b0;
            end
          end
        end

        PAD: begin
          rate_output          <= rate_output ^ pad_vec;
          input_buffer_ready   <= 1'b1;
          last_block_in_buffer <= 1'b1;
          is_last              <= 1'b1;
          state                <= HANDOFF;
        end

        HANDOFF: begin
          if (!input_buffer_ready) begin
            if (is_last) begin
              is_last <= 1'b0;
              state   <= IDLE;
            end else begin
              rate_output <= '0;
              word_cnt    <= '0;
              pad_pos     <= '0;
              if (pad_pending) begin
                state <= PAD;
              end else begin
                state     <= LOAD;
                ready_out <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_absorb_load_stage.sv
// Self-checking bench for absorb_load_stage: table of single-block messages plus
// hand-written multi-block, back-pressure and reset sequences.

module tb_absorb_load_stage;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   input_size;
  logic [31:0]   output_size_in;
  logic [1:0]    operation_mode_in;
  logic [63:0]   data_in;
  logic          valid_in;
  logic          ready_out;
  logic [1343:0] rate_output;
  logic [31:0]   output_size;
  logic [1:0]    operation_mode;
  logic          input_buffer_ready;
  logic          last_block_in_buffer;
  logic          input_buffer_ready_clr;
  logic          last_block_in_buffer_clr;

  absorb_load_stage dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .input_size               (input_size),
    .output_size_in           (output_size_in),
    .operation_mode_in        (operation_mode_in),
    .data_in                  (data_in),
    .valid_in                 (valid_in),
    .ready_out                (ready_out),
    .rate_output              (rate_output),
    .output_size              (output_size),
    .operation_mode           (operation_mode),
    .input_buffer_ready       (input_buffer_ready),
    .last_block_in_buffer     (last_block_in_buffer),
    .input_buffer_ready_clr   (input_buffer_ready_clr),
    .last_block_in_buffer_clr (last_block_in_buffer_clr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] mode;
    int         size;
    int         words;
    int         pad;
    int         endi;
    logic [7:0] endv;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] msg_byte(input int k);
    return 8'(k + 'h31);
  endfunction

  // Bytes past the end of the message carry 0xEE so masking is exercised.
  function automatic logic [63:0] msg_word(input int idx, input int size);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 8; j++)
      v[8*j +: 8] = (idx * 8 + j < size) ? msg_byte(idx * 8 + j) : 8'hEE;
    return v;
  endfunction

  function automatic logic [1343:0] exp_block(input int base, input int nbytes, input int pad,
                                              input int endi, input logic [7:0] endv);
    logic [1343:0] b;
    b = '0;
    for (int k = 0; k < nbytes; k++) b[8*k +: 8] = msg_byte(base + k);
    if (pad >= 0)  b[8*pad +: 8]  = 8'h1F;
    if (endi >= 0) b[8*endi +: 8] = endv;
    return b;
  endfunction

  // Reports the lowest differing byte (or byte 0 when the blocks agree).
  task automatic check_block(input string name, input logic [1343:0] exp);
    int bad;
    bad = 0;
    for (int i = 167; i >= 0; i--)
      if (rate_output[8*i +: 8] !== exp[8*i +: 8]) bad = i;
    check($sformatf("%s_byte%0d", name, bad), 64'(rate_output[8*bad +: 8]), 64'(exp[8*bad +: 8]));
  endtask

  task automatic do_start(input int size, input logic [31:0] osize, input logic [1:0] mode);
    start             = 1'b1;
    input_size        = 32'(size);
    output_size_in    = osize;
    operation_mode_in = mode;
    step();
    start = 1'b0;
  endtask

  // Offers words [first, last_excl) back to back; returns just after the final accepting edge.
  task automatic feed(input int first, input int last_excl, input int size);
    int  k;
    int  cyc;
    logic acc;
    k   = first;
    cyc = 0;
    while (k < last_excl && cyc < 100) begin
      data_in  = msg_word(k, size);
      valid_in = 1'b1;
      acc      = ready_out;
      step();
      if (acc) k++;
      cyc++;
    end
    valid_in = 1'b0;
    check("feed_words", 64'(k), 64'(last_excl));
  endtask

  task automatic clear_flags();
    input_buffer_ready_clr   = 1'b1;
    last_block_in_buffer_clr = 1'b1;
    step();
    input_buffer_ready_clr   = 1'b0;
    last_block_in_buffer_clr = 1'b0;
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b00,   0,  0,   0, 167, 8'h80};
    vecs[1] = '{2'b00,   3,  1,   3, 167, 8'h80};
    vecs[2] = '{2'b00, 167, 21, 167, 167, 8'h9F};
    vecs[3] = '{2'b01, 135, 17, 135, 135, 8'h9F};
    vecs[4] = '{2'b01,  20,  3,  20, 135, 8'h80};
    vecs[5] = '{2'b11,   8,  1,   8, 167, 8'h80};
    vecs[6] = '{2'b00, 160, 20, 160, 167, 8'h80};

    rst = 1'b0; start = 1'b0; input_size = '0; output_size_in = '0; operation_mode_in = '0;
    data_in = '0; valid_in = 1'b0; input_buffer_ready_clr = 1'b0; last_block_in_buffer_clr = 1'b0;
    step();
    step();
    check("rst_ready_out", 64'(ready_out), 64'd0);
    check("rst_ibr", 64'(input_buffer_ready), 64'd0);
    check("rst_last", 64'(last_block_in_buffer), 64'd0);
    check("rst_output_size", 64'(output_size), 64'd0);
    check("rst_mode", 64'(operation_mode), 64'd0);
    check_block("rst_rate", '0);
    rst = 1'b1;
    step();

    // Single-block messages with hand-computed pad positions.
    for (int i = 0; i < 7; i++) begin
      do_start(vecs[i].size, 32'h100 + 32'(i), vecs[i].mode);
      if (vecs[i].words > 0) begin
        check($sformatf("v%0d_start_ready", i), 64'(ready_out), 64'd1);
        feed(0, vecs[i].words, vecs[i].size);
      end
      check($sformatf("v%0d_ibr_early", i), 64'(input_buffer_ready), 64'd0);
      check($sformatf("v%0d_ready_pad", i), 64'(ready_out), 64'd0);
      step();
      check($sformatf("v%0d_ibr", i), 64'(input_buffer_ready), 64'd1);
      check($sformatf("v%0d_last", i), 64'(last_block_in_buffer), 64'd1);
      check_block($sformatf("v%0d_block", i),
                  exp_block(0, vecs[i].size, vecs[i].pad, vecs[i].endi, vecs[i].endv));
      check($sformatf("v%0d_osize", i), 64'(output_size), 64'h100 + 64'(i));
      check($sformatf("v%0d_mode", i), 64'(operation_mode), 64'(vecs[i].mode));
      clear_flags();
      check($sformatf("v%0d_idle_ready", i), 64'(ready_out), 64'd0);
      check($sformatf("v%0d_idle_ibr", i), 64'(input_buffer_ready), 64'd0);
    end

    // SHAKE256, 136 bytes: full data block, held back, then a pad-only block.
    do_start(136, 32'd64, 2'b01);
    feed(0, 17, 136);
    check("s256_b1_ibr", 64'(input_buffer_ready), 64'd1);
    check("s256_b1_last", 64'(last_block_in_buffer), 64'd0);
    check_block("s256_b1", exp_block(0, 136, -1, -1, 8'h00));
    for (int c = 0; c < 10; c++) begin
      data_in  = msg_word(17, 136);
      valid_in = 1'b1;
      step();
      check($sformatf("hold_ready_c%0d", c), 64'(ready_out), 64'd0);
    end
    valid_in = 1'b0;
    check_block("hold_block", exp_block(0, 136, -1, -1, 8'h00));
    check("hold_ibr", 64'(input_buffer_ready), 64'd1);
    input_buffer_ready_clr = 1'b1;
    step();
    input_buffer_ready_clr = 1'b0;
    check("s256_clr_ibr", 64'(input_buffer_ready), 64'd0);
    step();
    check("s256_pad_ibr", 64'(input_buffer_ready), 64'd0);
    step();
    check("s256_b2_ibr", 64'(input_buffer_ready), 64'd1);
    check("s256_b2_last", 64'(last_block_in_buffer), 64'd1);
    check_block("s256_b2", exp_block(0, 0, 0, 135, 8'h80));
    clear_flags();

    // SHAKE128, 200 bytes: start ignored mid-message, clear-to-ready latency, tail block.
    do_start(200, 32'h55, 2'b00);
    start = 1'b1; input_size = '0; output_size_in = 32'hDEAD; operation_mode_in = 2'b01;
    feed(0, 21, 200);
    start = 1'b0;
    check("s128_osize_held", 64'(output_size), 64'h55);
    check("s128_mode_held", 64'(operation_mode), 64'd0);
    check("s128_b1_ibr", 64'(input_buffer_ready), 64'd1);
    check("s128_b1_last", 64'(last_block_in_buffer), 64'd0);
    check_block("s128_b1", exp_block(0, 168, -1, -1, 8'h00));
    input_buffer_ready_clr = 1'b1;
    step();
    input_buffer_ready_clr = 1'b0;
    check("clr_ready_n1", 64'(ready_out), 64'd0);
    step();
    check("clr_ready_n2", 64'(ready_out), 64'd1);
    feed(21, 25, 200);
    check("s128_b2_ibr_early", 64'(input_buffer_ready), 64'd0);
    step();
    check("s128_b2_ibr", 64'(input_buffer_ready), 64'd1);
    check("s128_b2_last", 64'(last_block_in_buffer), 64'd1);
    check_block("s128_b2", exp_block(168, 32, 32, 167, 8'h80));
    clear_flags();

    // Reset after 5 words of a 400-byte message, then a pad-only message.
    do_start(400, 32'd7, 2'b00);
    feed(0, 5, 400);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_ibr", 64'(input_buffer_ready), 64'd0);
    check("mid_rst_last", 64'(last_block_in_buffer), 64'd0);
    check("mid_rst_ready", 64'(ready_out), 64'd0);
    check("mid_rst_osize", 64'(output_size), 64'd0);
    check_block("mid_rst_rate", '0);
    do_start(0, 32'd9, 2'b00);
    step();
    check("post_rst_ibr", 64'(input_buffer_ready), 64'd1);
    check("post_rst_last", 64'(last_block_in_buffer), 64'd1);
    check_block("post_rst_block", exp_block(0, 0, 0, 167, 8'h80));
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("flag_rst_ibr", 64'(input_buffer_ready), 64'd0);
    check("flag_rst_last", 64'(last_block_in_buffer), 64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
